// File: rtl/proc_run_ctrl_if.sv
// rtl/proc_run_ctrl_if.sv - VIO/debug-side signal bundle of the processor run controller
// master drives the VIO controls and debug bus; slave is the run controller.
interface proc_run_ctrl_if;
  logic         run;
  logic         step;
  logic [3:0]   sel;
  logic [1:0]   byte_sel;
  logic [319:0] probe_bus;
  logic [31:0]  bp_count;
  logic         proc_reset;
  logic         proc_ce;
  logic [1:0]   state;
  logic [31:0]  cycle_count;
  logic         bp_hit;
  logic [7:0]   final_result;

  modport master (
    output run, step, sel, byte_sel, probe_bus, bp_count,
    input  proc_reset, proc_ce, state, cycle_count, bp_hit, final_result
  );

  modport slave (
    input  run, step, sel, byte_sel, probe_bus, bp_count,
    output proc_reset, proc_ce, state, cycle_count, bp_hit, final_result
  );
endinterface

// File: rtl/proc_run_ctrl.sv
// rtl/proc_run_ctrl.sv - reset hold / run / halt / single-step sequencer and debug byte display
// Optional cycle breakpoint is built when PROC_BREAKPOINT_EN is defined.
module proc_run_ctrl #(
  parameter int RST_CYCLES = 4
) (
  input logic           clock,
  input logic           reset,
  proc_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    IDLE = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(RST_CYCLES - 1);

  state_t      state_r;
  logic [7:0]  hold_cnt;
  logic        step_q;
  logic        proc_ce;
  logic        proc_reset;
  logic [31:0] cycle_count;
  logic        bp_hit;
  logic [7:0]  final_result;
  logic [31:0] word;
  logic [7:0]  byte_pick;
  logic        step_edge;
  logic        bp_trip;

  assign step_edge = bus.step & ~step_q;

  always_comb begin
    word = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus.sel == 4'(i)) word = bus.probe_bus[i*32 +: 32];
    end
  end

  assign byte_pick = word[{bus.byte_sel, 3'b000} +: 8];

  // Trip one edge early so the enable is already low in the cycle where
  // cycle_count equals bp_count; the core sees exactly bp_count enables.
`ifdef PROC_BREAKPOINT_EN
  assign bp_trip = (cycle_count + {31'b0, proc_ce}) == bus.bp_count;
`else
  assign bp_trip = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= HOLD;
      hold_cnt     <= '0;
      step_q       <= 1'b0;
      proc_ce      <= 1'b0;
      proc_reset   <= 1'b1;
      cycle_count  <= '0;
      bp_hit       <= 1'b0;
      final_result <= '0;
    end else begin
      step_q       <= bus.step;
      cycle_count  <= cycle_count + {31'b0, proc_ce};
      final_result <= byte_pick;
      case (state_r)
        HOLD: begin
          proc_ce <= 1'b0;
          if (hold_cnt == HOLD_LAST) begin
            state_r    <= IDLE;
            proc_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        IDLE: begin
          if (bus.run && !bp_hit) begin
            if (bp_trip) begin
              bp_hit  <= 1'b1;
              proc_ce <= 1'b0;
            end else begin
              state_r <= RUN;
              proc_ce <= 1'b1;
            end
          end else if (step_edge) begin
            state_r <= STEP;
            proc_ce <= 1'b1;
            bp_hit  <= 1'b0;
          end else begin
            proc_ce <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.run) begin
            state_r <= IDLE;
            proc_ce <= 1'b0;
          end else if (bp_trip) begin
            state_r <= IDLE;
            proc_ce <= 1'b0;
            bp_hit  <= 1'b1;
          end else begin
            proc_ce <= 1'b1;
          end
        end
        STEP: begin
          state_r <= IDLE;
          proc_ce <= 1'b0;
        end
        default: begin
          state_r <= HOLD;
          proc_ce <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state        = state_r;
  assign bus.proc_ce      = proc_ce;
  assign bus.proc_reset   = proc_reset;
  assign bus.cycle_count  = cycle_count;
  assign bus.bp_hit       = bp_hit;
  assign bus.final_result = final_result;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb/tb_proc_run_ctrl.sv - directed self-checking bench for proc_run_ctrl
module tb_proc_run_ctrl;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  proc_run_ctrl_if bus ();

  proc_run_ctrl #(.RST_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step_pulse();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
  endtask

  task automatic reset_to_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.run       = 1'b0;
    bus.step      = 1'b0;
    bus.sel       = 4'd0;
    bus.byte_sel  = 2'd0;
    bus.probe_bus = '0;
    bus.bp_count  = 32'hFFFF_FFFF;

    tick();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_proc_reset", 32'(bus.proc_reset), 32'd1);
    check("rst_proc_ce", 32'(bus.proc_ce), 32'd0);
    check("rst_cycle_count", bus.cycle_count, 32'd0);
    check("rst_bp_hit", 32'(bus.bp_hit), 32'd0);
    check("rst_final_result", 32'(bus.final_result), 32'd0);

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_proc_reset", 32'(bus.proc_reset), 32'd1);
      check("hold_state", 32'(bus.state), 32'd0);
    end
    tick();
    check("idle_proc_reset", 32'(bus.proc_reset), 32'd0);
    check("idle_state", 32'(bus.state), 32'd1);
    check("idle_proc_ce", 32'(bus.proc_ce), 32'd0);

    bus.run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("run_proc_ce", 32'(bus.proc_ce), 32'd1);
      check("run_state", 32'(bus.state), 32'd2);
    end
    bus.run = 1'b0;
    tick();
    check("run_stop_ce", 32'(bus.proc_ce), 32'd0);
    check("run_stop_state", 32'(bus.state), 32'd1);
    check("run_count", bus.cycle_count, 32'd10);

    for (int p = 0; p < 3; p++) begin
      step_pulse();
      check("step_state", 32'(bus.state), 32'd3);
      check("step_ce", 32'(bus.proc_ce), 32'd1);
      tick();
      check("step_back_idle", 32'(bus.state), 32'd1);
      check("step_ce_low", 32'(bus.proc_ce), 32'd0);
      check("step_count", bus.cycle_count, 32'(11 + p));
      for (int i = 0; i < 3; i++) tick();
    end

    bus.run = 1'b1;
    tick();
    step_pulse();
    check("run_step_ignored", 32'(bus.state), 32'd2);
    tick();
    bus.run = 1'b0;
    tick();
    check("run_step_idle", 32'(bus.state), 32'd1);
    check("run_step_count", bus.cycle_count, 32'd16);
    tick();
    check("step_not_queued", 32'(bus.state), 32'd1);
    check("step_not_queued_cnt", bus.cycle_count, 32'd16);

    bus.run  = 1'b1;
    bus.step = 1'b1;
    tick();
    check("run_beats_step", 32'(bus.state), 32'd2);
    bus.run  = 1'b0;
    bus.step = 1'b0;
    tick();
    tick();
    check("run_beats_step_idle", 32'(bus.state), 32'd1);
    check("run_beats_step_cnt", bus.cycle_count, 32'd17);

    bus.probe_bus[95:64]   = 32'hA1B2_C3D4;
    bus.probe_bus[319:288] = 32'h5566_7788;
    bus.sel      = 4'd2;
    bus.byte_sel = 2'd1;
    check("disp_latency", 32'(bus.final_result), 32'h00);
    tick();
    check("disp_w2_b1", 32'(bus.final_result), 32'hC3);
    bus.byte_sel = 2'd3;
    tick();
    check("disp_w2_b3", 32'(bus.final_result), 32'hA1);
    bus.sel      = 4'd9;
    bus.byte_sel = 2'd0;
    tick();
    check("disp_w9_b0", 32'(bus.final_result), 32'h88);
    bus.sel = 4'd12;
    check("disp_hold", 32'(bus.final_result), 32'h88);
    tick();
    check("disp_sel12", 32'(bus.final_result), 32'h00);

    reset_to_idle();
    check("rerst_idle", 32'(bus.state), 32'd1);
    bus.run = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("mid_run_count", bus.cycle_count, 32'd7);
    check("mid_run_ce", 32'(bus.proc_ce), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_ce", 32'(bus.proc_ce), 32'd0);
    check("mid_rst_count", bus.cycle_count, 32'd0);
    check("mid_rst_state", 32'(bus.state), 32'd0);
    check("mid_rst_proc_reset", 32'(bus.proc_reset), 32'd1);
    reset   = 1'b0;
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rehold_proc_reset", 32'(bus.proc_reset), 32'd1);
    tick();
    check("rehold_idle", 32'(bus.state), 32'd1);
    check("rehold_proc_reset_low", 32'(bus.proc_reset), 32'd0);

`ifdef PROC_BREAKPOINT_EN
    bus.bp_count = 32'd20;
    bus.run      = 1'b1;
    tick();
    for (int i = 0; i < 40 && bus.state != 2'd1; i++) tick();
    check("bp_state", 32'(bus.state), 32'd1);
    check("bp_count_halt", bus.cycle_count, 32'd20);
    check("bp_hit_set", 32'(bus.bp_hit), 32'd1);
    check("bp_ce", 32'(bus.proc_ce), 32'd0);
    tick();
    tick();
    check("bp_blocks_run", 32'(bus.state), 32'd1);
    check("bp_blocks_cnt", bus.cycle_count, 32'd20);
    step_pulse();
    check("bp_step_state", 32'(bus.state), 32'd3);
    check("bp_step_clear", 32'(bus.bp_hit), 32'd0);
    tick();
    check("bp_step_count", bus.cycle_count, 32'd21);
    tick();
    check("bp_resume", 32'(bus.state), 32'd2);
    check("bp_resume_ce", 32'(bus.proc_ce), 32'd1);
    bus.run = 1'b0;
    reset_to_idle();
    bus.bp_count = 32'd0;
    bus.run      = 1'b1;
    tick();
    check("bp_zero_state", 32'(bus.state), 32'd1);
    check("bp_zero_hit", 32'(bus.bp_hit), 32'd1);
    check("bp_zero_ce", 32'(bus.proc_ce), 32'd0);
    bus.run = 1'b0;
`else
    bus.bp_count = 32'd5;
    bus.run      = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("nobp_state", 32'(bus.state), 32'd2);
    check("nobp_hit", 32'(bus.bp_hit), 32'd0);
    check("nobp_count", bus.cycle_count, 32'd9);
    bus.run = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/proc_run_ctrl.md
# proc_run_ctrl

Run controller for the single-cycle RISC-V `Processor` core on the FPGA board. It sequences the core's reset and clock-enable under VIO control: power-on reset hold, free run, halt, and single-step. It counts executed cycles. It selects one byte of the ten 32-bit debug outputs onto the 8-bit `final_result` LEDs. It sits between the VIO/board top level and the `Processor` instance and replaces the raw VIO-driven reset.

## Interface
- `RST_CYCLES`, 4: cycles `proc_reset` is held high after `reset`; legal range 1–255.
- `clock` in 1: board clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level input from VIO; run while high.
- `step` in 1: from VIO; a rising edge executes one core cycle.
- `sel` in 4: debug word select, 0–9.
- `byte_sel` in 2: byte of the selected word; 0 selects bits [7:0], 3 selects bits [31:24].
- `probe_bus` in 320: core debug outputs concatenated; output1 is at bits [31:0], output10 at bits [319:288].
- `bp_count` in 32: breakpoint cycle count (see Configuration).
- `proc_reset` out 1: reset to `Processor`.
- `proc_ce` out 1: clock enable to `Processor`; the core advances only when this is 1.
- `state` out 2: 0=HOLD, 1=IDLE, 2=RUN, 3=STEP.
- `cycle_count` out 32: number of cycles with `proc_ce`=1.
- `bp_hit` out 1: sticky breakpoint flag.
- `final_result` out 8: registered display byte.

## Operation
- States:
  - HOLD: `proc_reset`=1, `proc_ce`=0. The hold counter counts `RST_CYCLES` cycles, then the state goes to IDLE.
  - IDLE: `proc_reset`=0, `proc_ce`=0. The core is halted.
  - RUN: `proc_ce`=1 every cycle.
  - STEP: `proc_ce`=1 for exactly one cycle, then IDLE.
- Transitions out of IDLE, in priority order:
  1. `run`=1 and `bp_hit`=0 → RUN.
  2. Otherwise, a `step` rising edge → STEP.
- Other transitions:
  - RUN with `run`=0 → IDLE.
  - STEP is entered only from IDLE. Step edges seen in HOLD, RUN or STEP are discarded, not queued.
- Step edge detect: `step_q` is a registered copy of `step`; an edge is `step & ~step_q`. `step_q` resets to 0.
- `cycle_count` increments on every cycle with `proc_ce`=1. It is 32-bit and wraps from 0xFFFFFFFF to 0. It is cleared only by `reset`.
- Display byte:
  - `final_result` = byte `byte_sel` of word `sel`, registered with 1-cycle latency.
  - `sel` values 10–15 give 0x00.
- `proc_ce`, `proc_reset` and `state` are registered outputs, not decoded combinationally from inputs.

## Timing
- Reset values:
  - `state`=HOLD, `proc_reset`=1, `proc_ce`=0.
  - `cycle_count`=0, `bp_hit`=0, `final_result`=0x00.
  - Hold counter=0.
- `reset` asserted in any state, including mid-RUN or mid-STEP: on the next edge the block is at reset values and `proc_ce` drops to 0 that cycle. The full `RST_CYCLES` hold restarts after `reset` is released.
- After `reset` is released, `proc_reset` stays high for exactly `RST_CYCLES` cycles. IDLE is visible on cycle `RST_CYCLES`+1.
- `run` rising while in IDLE: `state`=RUN and `proc_ce`=1 on the next edge.
- `run` falling: `proc_ce`=0 on the next edge.
- Step edge at edge N: STEP with `proc_ce`=1 during cycle N+1, IDLE at N+2.
- `run` and a step edge in the same IDLE cycle: `run` wins; the step edge is discarded.

## Configuration
- `PROC_BREAKPOINT_EN` defined:
  - In RUN, on a cycle where `cycle_count` == `bp_count`, `proc_ce` is forced to 0 in that same cycle. The state goes to IDLE and `bp_hit` is set to 1.
  - The core therefore executes exactly `bp_count` enabled cycles.
  - While `bp_hit`=1, IDLE→RUN is blocked.
  - A step edge in IDLE clears `bp_hit` and performs one step. After that, `run` resumes normally.
  - `bp_count`=0 with `cycle_count`=0 breaks immediately on entering RUN.
- `PROC_BREAKPOINT_EN` undefined:
  - `bp_count` is ignored and `bp_hit` is constant 0.
  - The port list is identical in both builds.

## Test plan
- Reset release with `RST_CYCLES`=4 → `proc_reset`=1 for exactly 4 cycles, then `state`=1 (IDLE) with `proc_ce`=0.
- `run`=1 held for 10 cycles, then 0 → `proc_ce` high for exactly 10 cycles and `cycle_count`=10.
- Three `step` pulses 5 cycles apart in IDLE, plus one pulse during RUN → `cycle_count` increases by exactly 3 from the IDLE pulses; the RUN pulse adds nothing.
- `reset` asserted mid-RUN at `cycle_count`=7 → next edge `proc_ce`=0, `cycle_count`=0, `state`=HOLD.
- `probe_bus` word 2 = 0xA1B2C3D4, `sel`=2, `byte_sel`=1 → `final_result`=0xC3 one cycle later. With `sel`=12 → 0x00.
- `PROC_BREAKPOINT_EN` build, `bp_count`=20, `run` held at 1:
  - The core halts at `cycle_count`=20 and `bp_hit`=1, with `run` still high.
  - One step edge → `cycle_count`=21, `bp_hit`=0, then RUN resumes.
